// File: rtl/board_pkg.sv
// Shared definitions for the board store: cell codes, FSM states and default board geometry.
package board_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_TRI   = 2'b01;
    localparam logic [1:0] CELL_CIRC  = 2'b10;
    localparam logic [1:0] CELL_MARK  = 2'b11;

    localparam int unsigned DEF_BOARD_W = 10;
    localparam int unsigned DEF_BOARD_H = 10;
    localparam int unsigned DEF_ADDR_W  = 7;
    localparam int unsigned DEF_CNT_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StClear
    } state_e;

endpackage

// File: rtl/board_store_if.sv
// Move-request handshake between the game controller (master) and the board store (slave).
interface board_store_if;

    logic       mv_valid;
    logic       mv_ready;
    logic [3:0] mv_x;
    logic [3:0] mv_y;
    logic [1:0] mv_player;
    logic       mv_done;
    logic       mv_ok;

    modport master (
        output mv_valid, mv_x, mv_y, mv_player,
        input  mv_ready, mv_done, mv_ok
    );

    modport slave (
        input  mv_valid, mv_x, mv_y, mv_player,
        output mv_ready, mv_done, mv_ok
    );

endinterface

// File: rtl/board_cell_array.sv
// Flop array of 2-bit cell codes: async reset, one synchronous write port and two
// combinational read ports (display and move checker). Out-of-range reads return empty.
module board_cell_array
    import board_pkg::*;
#(
    parameter int unsigned NCELLS = 100,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_data,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic [1:0]        chk_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_data
);

    logic [1:0] cells_q [NCELLS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCELLS; i++) begin
                cells_q[i] <= CELL_EMPTY;
            end
        end else if (wr_en && (32'(wr_addr) < NCELLS)) begin
            cells_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = CELL_EMPTY;
        if (32'(rd_addr) < NCELLS) begin
            rd_data = cells_q[rd_addr];
        end
    end

    always_comb begin
        chk_data = CELL_EMPTY;
        if (32'(chk_addr) < NCELLS) begin
            chk_data = cells_q[chk_addr];
        end
    end

endmodule

// File: rtl/board_store.sv
// Board state memory with move validation, per-player move counters, last-position
// registers and a one-cell-per-cycle clear sequencer.
module board_store
    import board_pkg::*;
#(
    parameter int unsigned BOARD_W = DEF_BOARD_W,
    parameter int unsigned BOARD_H = DEF_BOARD_H,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_data,
    board_store_if.slave      mv,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [CNT_W-1:0]  mov_tri,
    output logic [CNT_W-1:0]  mov_circ,
    output logic [4:0]        rp_x,
    output logic [4:0]        rp_y
);

    localparam int unsigned NCELLS = BOARD_W * BOARD_H;

    state_e              state_q, state_d;
    logic [3:0]          x_q, x_d;
    logic [3:0]          y_q, y_d;
    logic [1:0]          player_q, player_d;
    logic                pending_q, pending_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_tri_q, cnt_tri_d;
    logic [CNT_W-1:0]    cnt_circ_q, cnt_circ_d;
    logic [4:0]          rp_x_q, rp_x_d;
    logic [4:0]          rp_y_q, rp_y_d;
    logic                done_q, done_d;
    logic                ok_q, ok_d;

    logic [ADDR_W-1:0]   cell_addr;
    logic [1:0]          chk_data;
    logic                legal;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [1:0]          wr_data;

    board_cell_array #(
        .NCELLS (NCELLS),
        .ADDR_W (ADDR_W)
    ) u_cells (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .chk_addr (cell_addr),
        .chk_data (chk_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    assign cell_addr = ADDR_W'(32'(x_q) + 32'(y_q) * BOARD_W);

    // Marks overwrite anything; pieces need an in-range, empty target.
    always_comb begin
        legal = (32'(x_q) < BOARD_W) && (32'(y_q) < BOARD_H) && (player_q != CELL_EMPTY);
        if ((player_q == CELL_TRI || player_q == CELL_CIRC) && chk_data != CELL_EMPTY) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        player_d   = player_q;
        pending_d  = pending_q;
        idx_d      = idx_q;
        cnt_tri_d  = cnt_tri_q;
        cnt_circ_d = cnt_circ_q;
        rp_x_d     = rp_x_q;
        rp_y_d     = rp_y_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        wr_en      = 1'b0;
        wr_addr    = cell_addr;
        wr_data    = player_q;

        unique case (state_q)
            StIdle: begin
                if (mv.mv_valid) begin
                    x_d       = mv.mv_x;
                    y_d       = mv.mv_y;
                    player_d  = mv.mv_player;
                    pending_d = clr_start;
                    state_d   = StCheck;
                end else if (clr_start) begin
                    state_d    = StClear;
                    idx_d      = '0;
                    cnt_tri_d  = '0;
                    cnt_circ_d = '0;
                    rp_x_d     = '0;
                    rp_y_d     = '0;
                end
            end
            StCheck: begin
                done_d = 1'b1;
                ok_d   = legal;
                if (legal) begin
                    wr_en = 1'b1;
                    if (player_q == CELL_TRI) begin
                        if (cnt_tri_q != '1) cnt_tri_d = cnt_tri_q + CNT_W'(1);
                        rp_x_d = {1'b0, x_q};
                        rp_y_d = {1'b0, y_q};
                    end else if (player_q == CELL_CIRC) begin
                        if (cnt_circ_q != '1) cnt_circ_d = cnt_circ_q + CNT_W'(1);
                        rp_x_d = {1'b0, x_q};
                        rp_y_d = {1'b0, y_q};
                    end
                end
                if (pending_q || clr_start) begin
                    state_d    = StClear;
                    pending_d  = 1'b0;
                    idx_d      = '0;
                    cnt_tri_d  = '0;
                    cnt_circ_d = '0;
                    rp_x_d     = '0;
                    rp_y_d     = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StClear: begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_data = CELL_EMPTY;
                if (idx_q == ADDR_W'(NCELLS - 1)) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            player_q   <= CELL_EMPTY;
            pending_q  <= 1'b0;
            idx_q      <= '0;
            cnt_tri_q  <= '0;
            cnt_circ_q <= '0;
            rp_x_q     <= '0;
            rp_y_q     <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            player_q   <= player_d;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            cnt_tri_q  <= cnt_tri_d;
            cnt_circ_q <= cnt_circ_d;
            rp_x_q     <= rp_x_d;
            rp_y_q     <= rp_y_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
        end
    end

    assign mv.mv_ready = (state_q == StIdle);
    assign mv.mv_done  = done_q;
    assign mv.mv_ok    = ok_q;
    assign clr_busy    = (state_q == StClear);
    assign mov_tri     = cnt_tri_q;
    assign mov_circ    = cnt_circ_q;
    assign rp_x        = rp_x_q;
    assign rp_y        = rp_y_q;

endmodule

// File: tb/tb_board_store.sv
// Directed self-checking bench for board_store: placement, rejection, saturation,
// clear sequencing and reset during a clear sweep.
module tb_board_store;

    logic       clk;
    logic       rst_n;
    logic [6:0] rd_addr;
    logic [1:0] rd_data;
    logic       clr_start;
    logic       clr_busy;
    logic [3:0] mov_tri;
    logic [3:0] mov_circ;
    logic [4:0] rp_x;
    logic [4:0] rp_y;

    int total = 0;
    int bad   = 0;

    board_store_if mv ();

    board_store dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .mv        (mv.slave),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .mov_tri   (mov_tri),
        .mov_circ  (mov_circ),
        .rp_x      (rp_x),
        .rp_y      (rp_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one move; returns the cell value seen just after acceptance and mv_done/mv_ok
    // sampled in the cycle after the write edge.
    task automatic issue_move(input logic [3:0] x, input logic [3:0] y, input logic [1:0] p,
                              input logic with_clr, output logic done, output logic ok,
                              output logic [1:0] pre_rd);
        int guard = 0;
        @(negedge clk);
        while (!mv.mv_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!mv.mv_ready) begin
            total++;
            bad++;
            $display("FAIL move_wait: mv_ready=0 after %0d cycles, required 1", guard);
        end
        mv.mv_valid  = 1'b1;
        mv.mv_x      = x;
        mv.mv_y      = y;
        mv.mv_player = p;
        clr_start    = with_clr;
        @(posedge clk);
        #1;
        mv.mv_valid = 1'b0;
        clr_start   = 1'b0;
        pre_rd      = rd_data;
        @(posedge clk);
        #1;
        done = mv.mv_done;
        ok   = mv.mv_ok;
    endtask

    task automatic test_reset();
        int nz = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (mv.mv_ready !== 1'b1 || mv.mv_done !== 1'b0 || mv.mv_ok !== 1'b0
            || clr_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ready=%b done=%b ok=%b busy=%b, required 1 0 0 0",
                     mv.mv_ready, mv.mv_done, mv.mv_ok, clr_busy);
        end
        total++;
        if (mov_tri !== 4'd0 || mov_circ !== 4'd0 || rp_x !== 5'd0 || rp_y !== 5'd0) begin
            bad++;
            $display("FAIL reset_cnt: tri=%0d circ=%0d rp=(%0d,%0d), required 0 0 (0,0)",
                     mov_tri, mov_circ, rp_x, rp_y);
        end
        for (int a = 0; a < 128; a++) begin
            rd_addr = 7'(a);
            #1;
            if (rd_data !== 2'b00) nz++;
        end
        total++;
        if (nz !== 0) begin
            bad++;
            $display("FAIL reset_cells: %0d nonzero cells, required 0", nz);
        end
    endtask

    task automatic test_place();
        logic done, ok;
        logic [1:0] pre;
        rd_addr = 7'd43;
        issue_move(4'd3, 4'd4, 2'b01, 1'b0, done, ok, pre);
        total++;
        if (pre !== 2'b00) begin
            bad++;
            $display("FAIL place_pre: rd=%b before write edge, required 00", pre);
        end
        total++;
        if (done !== 1'b1 || ok !== 1'b1) begin
            bad++;
            $display("FAIL place_done: done=%b ok=%b, required 1 1", done, ok);
        end
        total++;
        if (rd_data !== 2'b01 || mov_tri !== 4'd1 || rp_x !== 5'd3 || rp_y !== 5'd4) begin
            bad++;
            $display("FAIL place_state: rd=%b tri=%0d rp=(%0d,%0d), required 01 1 (3,4)",
                     rd_data, mov_tri, rp_x, rp_y);
        end
        total++;
        if (mv.mv_ready !== 1'b1) begin
            bad++;
            $display("FAIL place_ready: mv_ready=%b, required 1", mv.mv_ready);
        end
    endtask

    task automatic test_occupied_and_mark();
        logic done, ok;
        logic [1:0] pre;
        rd_addr = 7'd43;
        issue_move(4'd3, 4'd4, 2'b10, 1'b0, done, ok, pre);
        total++;
        if (done !== 1'b1 || ok !== 1'b0 || rd_data !== 2'b01 || mov_circ !== 4'd0) begin
            bad++;
            $display("FAIL occupied: done=%b ok=%b rd=%b circ=%0d, required 1 0 01 0",
                     done, ok, rd_data, mov_circ);
        end
        issue_move(4'd3, 4'd4, 2'b11, 1'b0, done, ok, pre);
        total++;
        if (ok !== 1'b1 || rd_data !== 2'b11) begin
            bad++;
            $display("FAIL mark: ok=%b rd=%b, required 1 11", ok, rd_data);
        end
        total++;
        if (mov_tri !== 4'd1 || mov_circ !== 4'd0 || rp_x !== 5'd3 || rp_y !== 5'd4) begin
            bad++;
            $display("FAIL mark_side: tri=%0d circ=%0d rp=(%0d,%0d), required 1 0 (3,4)",
                     mov_tri, mov_circ, rp_x, rp_y);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (mv.mv_done !== 1'b0 || mv.mv_ok !== 1'b1) begin
            bad++;
            $display("FAIL ok_hold: done=%b ok=%b, required 0 1", mv.mv_done, mv.mv_ok);
        end
    endtask

    task automatic test_reject();
        logic done, ok;
        logic [1:0] pre;
        issue_move(4'd10, 4'd0, 2'b01, 1'b0, done, ok, pre);
        total++;
        if (done !== 1'b1 || ok !== 1'b0) begin
            bad++;
            $display("FAIL rej_x: done=%b ok=%b, required 1 0", done, ok);
        end
        issue_move(4'd0, 4'd10, 2'b10, 1'b0, done, ok, pre);
        total++;
        if (done !== 1'b1 || ok !== 1'b0) begin
            bad++;
            $display("FAIL rej_y: done=%b ok=%b, required 1 0", done, ok);
        end
        rd_addr = 7'd0;
        issue_move(4'd0, 4'd0, 2'b00, 1'b0, done, ok, pre);
        total++;
        if (done !== 1'b1 || ok !== 1'b0 || rd_data !== 2'b00) begin
            bad++;
            $display("FAIL rej_player: done=%b ok=%b rd=%b, required 1 0 00", done, ok, rd_data);
        end
        total++;
        if (mov_tri !== 4'd1 || mov_circ !== 4'd0 || rp_x !== 5'd3 || rp_y !== 5'd4) begin
            bad++;
            $display("FAIL rej_side: tri=%0d circ=%0d rp=(%0d,%0d), required 1 0 (3,4)",
                     mov_tri, mov_circ, rp_x, rp_y);
        end
    endtask

    task automatic test_saturate();
        logic done, ok;
        logic [1:0] pre;
        int not_ok = 0;
        for (int i = 0; i < 16; i++) begin
            issue_move(4'(i % 10), 4'(5 + i / 10), 2'b10, 1'b0, done, ok, pre);
            if (ok !== 1'b1) not_ok++;
            if (i == 14) begin
                total++;
                if (mov_circ !== 4'd15) begin
                    bad++;
                    $display("FAIL circ_15: mov_circ=%0d, required 15", mov_circ);
                end
            end
        end
        total++;
        if (not_ok !== 0) begin
            bad++;
            $display("FAIL circ_moves: %0d rejected, required 0", not_ok);
        end
        total++;
        if (mov_circ !== 4'd15 || rp_x !== 5'd5 || rp_y !== 5'd6) begin
            bad++;
            $display("FAIL circ_sat: circ=%0d rp=(%0d,%0d), required 15 (5,6)",
                     mov_circ, rp_x, rp_y);
        end
    endtask

    task automatic test_clear_with_move();
        logic done, ok;
        logic [1:0] pre;
        int cnt = 0;
        int ready_hi = 0;
        int nz = 0;
        issue_move(4'd7, 4'd7, 2'b01, 1'b1, done, ok, pre);
        total++;
        if (done !== 1'b1 || ok !== 1'b1 || clr_busy !== 1'b1 || mv.mv_ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_entry: done=%b ok=%b busy=%b ready=%b, required 1 1 1 0",
                     done, ok, clr_busy, mv.mv_ready);
        end
        total++;
        if (mov_tri !== 4'd0 || mov_circ !== 4'd0 || rp_x !== 5'd0 || rp_y !== 5'd0) begin
            bad++;
            $display("FAIL clr_zero: tri=%0d circ=%0d rp=(%0d,%0d), required 0 0 (0,0)",
                     mov_tri, mov_circ, rp_x, rp_y);
        end
        rd_addr = 7'd77;
        while (clr_busy && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
            if (clr_busy && mv.mv_ready) ready_hi++;
            if (cnt == 77) begin
                total++;
                if (rd_data !== 2'b01) begin
                    bad++;
                    $display("FAIL clr_before77: rd=%b, required 01", rd_data);
                end
            end
            if (cnt == 78) begin
                total++;
                if (rd_data !== 2'b00) begin
                    bad++;
                    $display("FAIL clr_after77: rd=%b, required 00", rd_data);
                end
            end
            clr_start = (cnt == 30);
        end
        clr_start = 1'b0;
        total++;
        if (cnt !== 100 || ready_hi !== 0) begin
            bad++;
            $display("FAIL clr_len: busy edges=%0d ready_high=%0d, required 100 0", cnt, ready_hi);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (clr_busy !== 1'b0 || mv.mv_ready !== 1'b1) begin
            bad++;
            $display("FAIL clr_exit: busy=%b ready=%b, required 0 1", clr_busy, mv.mv_ready);
        end
        for (int a = 0; a < 128; a++) begin
            rd_addr = 7'(a);
            #1;
            if (rd_data !== 2'b00) nz++;
        end
        total++;
        if (nz !== 0 || mov_tri !== 4'd0 || mov_circ !== 4'd0 || rp_x !== 5'd0) begin
            bad++;
            $display("FAIL clr_result: nonzero=%0d tri=%0d circ=%0d rp_x=%0d, required 0 0 0 0",
                     nz, mov_tri, mov_circ, rp_x);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic done, ok;
        logic [1:0] pre;
        rd_addr = 7'd82;
        issue_move(4'd2, 4'd8, 2'b10, 1'b0, done, ok, pre);
        @(negedge clk);
        clr_start = 1'b1;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        total++;
        if (rd_data !== 2'b10 || clr_busy !== 1'b1) begin
            bad++;
            $display("FAIL midclr_pre: rd=%b busy=%b, required 10 1", rd_data, clr_busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (rd_data !== 2'b00 || clr_busy !== 1'b0 || mv.mv_ready !== 1'b1) begin
            bad++;
            $display("FAIL midclr_rst: rd=%b busy=%b ready=%b, required 00 0 1",
                     rd_data, clr_busy, mv.mv_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue_move(4'd2, 4'd8, 2'b01, 1'b0, done, ok, pre);
        total++;
        if (ok !== 1'b1 || rd_data !== 2'b01 || mov_tri !== 4'd1) begin
            bad++;
            $display("FAIL midclr_after: ok=%b rd=%b tri=%0d, required 1 01 1",
                     ok, rd_data, mov_tri);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        rd_addr      = 7'd0;
        clr_start    = 1'b0;
        mv.mv_valid  = 1'b0;
        mv.mv_x      = 4'd0;
        mv.mv_y      = 4'd0;
        mv.mv_player = 2'b00;
        test_reset();
        test_place();
        test_occupied_and_mark();
        test_reject();
        test_saturate();
        test_clear_with_move();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
